switch_poll_ctrl: RTL and testbench
===================================

# switch_poll_ctrl

Avalon-MM master controller that sequences periodic reads of the slide-switch PIO (18-bit input port at word address 0). Each sample is debounced over consecutive identical reads, and the block publishes a stable switch word, a one-cycle change strobe and a maskable rising-edge capture/interrupt. The traffic-light FSM reads mode/config switches from this block without polling the bus itself.

## Interface
- WIDTH, 18, switch bits used from readdata[WIDTH-1:0]
- POLL_CYCLES, 50000, clk cycles between read launches (1 ms at 50 MHz); must be ≥ 4
- DEBOUNCE_SAMPLES, 4, consecutive identical samples needed to accept a value; must be ≥ 1
- TIMEOUT_CYCLES, 16, max cycles in WAIT for readdatavalid

- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; one clock; all registers reset on the clk edge where reset=1
- enable  in  1  1 = polling runs; 0 = no new reads launched
- avm_address  out  2  constant 2'd0
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data; bits above WIDTH ignored
- avm_readdatavalid  in  1  read data valid
- sw_stable  out  WIDTH  debounced switch value
- sw_changed  out  1  one-cycle pulse when sw_stable updates
- edge_capture  out  WIDTH  sticky rising-edge flags of sw_stable
- edge_clear  in  WIDTH  write-1-to-clear for edge_capture, sampled each cycle
- irq_mask  in  WIDTH  interrupt enable per bit
- irq  out  1  |(edge_capture & irq_mask), combinational from registers
- bus_error  out  1  sticky read-timeout flag, cleared only by reset

## Operation
- States: IDLE, READ, WAIT, EVAL.
- IDLE: poll timer counts down from POLL_CYCLES-1 while enable=1; held at POLL_CYCLES-1 while enable=0. At 0 with enable=1, go to READ next cycle.
- READ: avm_read=1. Leave for WAIT on the first cycle in which avm_waitrequest=0. No timeout in READ; the request is never withdrawn.
- WAIT: avm_read=0. On avm_readdatavalid=1, register readdata[WIDTH-1:0] as sample and go to EVAL. If TIMEOUT_CYCLES pass without valid, set bus_error, discard, and go to IDLE. A late readdatavalid outside WAIT is ignored.
- EVAL (one cycle), then IDLE with the timer reloaded:
  - sample == sample_prev: match_cnt increments, saturating at DEBOUNCE_SAMPLES-1.
  - Otherwise: sample_prev ← sample, match_cnt ← 0.
  - With DEBOUNCE_SAMPLES=1, every sample qualifies.
  - If the post-update match_cnt == DEBOUNCE_SAMPLES-1 and sample != sw_stable: sw_stable ← sample, sw_changed=1 for one cycle, edge_capture |= sample & ~old sw_stable.
- edge_capture clearing: bits set in edge_clear clear the next cycle. A set and a clear on the same bit in the same cycle leave the bit set.
- enable falling during READ/WAIT: the transaction and EVAL complete, then the block parks in IDLE.
- Reset values: state IDLE, timer POLL_CYCLES-1, avm_read 0, sw_stable 0, sample_prev 0, match_cnt 0, sw_changed 0, edge_capture 0, bus_error 0, so irq 0.

## Timing
- With no stall: READ at T0 (accepted), readdatavalid at T1 (WAIT), EVAL at T2. sw_stable/sw_changed/edge_capture are visible at T3.
- Launch period is POLL_CYCLES + transaction cycles; the timer does not run during READ/WAIT/EVAL.
- Minimum latency from a switch change to sw_stable ≈ DEBOUNCE_SAMPLES polls.
- Reset asserted mid-transaction: avm_read is 0 on the cycle after the reset edge, and any outstanding readdatavalid is ignored.
- irq follows edge_capture/irq_mask in the same cycle, with no extra register.

## Test plan
- Reset, then enable=1, slave returns 0x00005 constantly (DEBOUNCE_SAMPLES=4, POLL_CYCLES=8) -> after the 4th read, sw_stable=0x00005, one sw_changed pulse, edge_capture=0x00005, irq=1 with irq_mask=0x3FFFF.
- Bounce sequence 0x1,0x0,0x1,0x1,0x1,0x1 -> sw_stable becomes 0x1 only after the 6th sample; no sw_changed earlier.
- Slave holds waitrequest=1 for 5 cycles -> avm_read held high for all 6 cycles, then normal completion; bus_error stays 0.
- readdatavalid never returned -> bus_error=1 exactly TIMEOUT_CYCLES after entering WAIT; next poll proceeds; a late valid causes no state change.
- edge_capture=0x00004 with edge_clear=0x00004 pulsed in the same cycle as a new rising edge on bit 2 -> bit 2 remains 1. A separate clear clears it to 0 and irq drops.
- enable=0 during WAIT, then reset asserted mid-READ in a second run -> first run: read completes, no further avm_read. Second run: all outputs return to reset values the cycle after the reset edge.

Source files
------------

// File: rtl/switch_poll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : switch_poll_ctrl
//  Purpose  : Avalon-MM master that periodically reads the slide-switch PIO
//             (word address 0), debounces the sampled value over consecutive
//             identical reads and publishes a stable switch word, a one-cycle
//             change strobe and maskable sticky rising-edge flags with irq.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                in   single clock
//    reset              in   synchronous active-high reset
//    enable             in   1 = launch periodic reads, 0 = park in IDLE
//    avm_address        out  always word address 0
//    avm_read           out  read request (held until waitrequest drops)
//    avm_waitrequest    in   slave stall
//    avm_readdata       in   read data, bits above WIDTH ignored
//    avm_readdatavalid  in   read data valid (only honoured while waiting)
//    sw_stable          out  debounced switch word
//    sw_changed         out  one-cycle pulse when sw_stable updates
//    edge_capture       out  sticky rising-edge flags of sw_stable
//    edge_clear         in   write-1-to-clear for edge_capture
//    irq_mask           in   per-bit interrupt enable
//    irq                out  |(edge_capture & irq_mask)
//    bus_error          out  sticky read-timeout flag
//  Parameter limits: POLL_CYCLES >= 4, DEBOUNCE_SAMPLES >= 1,
//  TIMEOUT_CYCLES >= 1, WIDTH <= 32.
// ============================================================================
module switch_poll_ctrl #(
    parameter int WIDTH            = 18,
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_readdatavalid,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] edge_capture,
    input  logic [WIDTH-1:0] edge_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
    output logic             bus_error
);

    localparam int TMR_W = (POLL_CYCLES > 1)      ? $clog2(POLL_CYCLES)      : 1;
    localparam int WCT_W = (TIMEOUT_CYCLES > 1)   ? $clog2(TIMEOUT_CYCLES)   : 1;
    localparam int CNT_W = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;

    localparam logic [TMR_W-1:0] c_tmr_reload = TMR_W'(POLL_CYCLES - 1);
    localparam logic [WCT_W-1:0] c_wait_last  = WCT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = CNT_W'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic [WCT_W-1:0]   wcnt_q,    wcnt_d;
    logic [WIDTH-1:0]   sample_q,  sample_d;
    logic [WIDTH-1:0]   prev_q,    prev_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   stable_q,  stable_d;
    logic               changed_q, changed_d;
    logic [WIDTH-1:0]   edge_q,    edge_d;
    logic               buserr_q,  buserr_d;

    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_accept;

    // Upper read-data bits carry nothing for this block.
    generate
        if (WIDTH < 32) begin : g_unused
            logic w_unused_rdata;
            assign w_unused_rdata = ^avm_readdata[31:WIDTH];
        end
    endgenerate

    // Debounce bookkeeping for the sample held in sample_q (used in EVAL).
    always_comb begin
        w_cnt_next = '0;
        if (sample_q == prev_q) begin
            w_cnt_next = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign w_accept = (w_cnt_next == c_cnt_max) && (sample_q != stable_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        wcnt_d    = wcnt_q;
        sample_d  = sample_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        // A clear takes effect next cycle; a same-cycle set below wins.
        edge_d    = edge_q & ~edge_clear;
        buserr_d  = buserr_q;

        unique case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    timer_d = c_tmr_reload;
                end else if (timer_q == '0) begin
                    // Reload now so the timer is fresh whichever way the
                    // transaction ends (EVAL or timeout).
                    state_d = S_READ;
                    timer_d = c_tmr_reload;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_READ: begin
                if (!avm_waitrequest) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[WIDTH-1:0];
                    state_d  = S_EVAL;
                end else if (wcnt_q == c_wait_last) begin
                    buserr_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                prev_d  = sample_q;
                cnt_d   = w_cnt_next;
                state_d = S_IDLE;
                if (w_accept) begin
                    stable_d  = sample_q;
                    changed_d = 1'b1;
                    edge_d    = edge_d | (sample_q & ~stable_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= c_tmr_reload;
            wcnt_q    <= '0;
            sample_q  <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
            edge_q    <= '0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            wcnt_q    <= wcnt_d;
            sample_q  <= sample_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            edge_q    <= edge_d;
            buserr_q  <= buserr_d;
        end
    end

    assign avm_address  = 2'd0;
    assign avm_read     = (state_q == S_READ);
    assign sw_stable    = stable_q;
    assign sw_changed   = changed_q;
    assign edge_capture = edge_q;
    assign irq          = |(edge_q & irq_mask);
    assign bus_error    = buserr_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_poll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_poll_ctrl
//  Purpose  : Directed, table-driven self-checking bench for switch_poll_ctrl
//             (WIDTH=18, POLL_CYCLES=8, DEBOUNCE_SAMPLES=4, TIMEOUT_CYCLES=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_poll_ctrl;

    localparam int W  = 18;
    localparam int P  = 8;
    localparam int D  = 4;
    localparam int T  = 16;
    localparam logic [W-1:0] ALL = 18'h3FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic          avm_readdatavalid;
    logic [W-1:0]  sw_stable;
    logic          sw_changed;
    logic [W-1:0]  edge_capture;
    logic [W-1:0]  edge_clear;
    logic [W-1:0]  irq_mask;
    logic          irq;
    logic          bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_poll_ctrl #(
        .WIDTH(W), .POLL_CYCLES(P), .DEBOUNCE_SAMPLES(D), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .sw_stable(sw_stable), .sw_changed(sw_changed),
        .edge_capture(edge_capture), .edge_clear(edge_clear),
        .irq_mask(irq_mask), .irq(irq), .bus_error(bus_error)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] clr;
        logic [W-1:0] exp_stable;
        logic         exp_changed;
        logic [W-1:0] exp_edge;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One slave-side transaction. Returns at the negedge of the cycle after
    // EVAL (respond=1) or of the first WAIT cycle (respond=0).
    task automatic poll(input logic [W-1:0] data, input int stall, input bit respond,
                        input logic [W-1:0] eval_clr, output int wait_n, output int rd_cycles);
        avm_waitrequest = (stall > 0);
        wait_n    = 0;
        rd_cycles = 0;
        while (!avm_read && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (!avm_read) begin
            check("read_launch", {31'd0, avm_read}, 32'd1);
            return;
        end
        for (int c = 1; c <= stall + 1; c++) begin
            if (avm_read) rd_cycles++;
            avm_waitrequest = (c <= stall);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        if (respond) begin
            avm_readdata      = {14'h2A5C, data};
            avm_readdatavalid = 1'b1;
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            edge_clear        = eval_clr;
            @(negedge clk);
            edge_clear        = '0;
        end
    endtask

    task automatic wait_read(output bit seen);
        int n = 0;
        while (!avm_read && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = avm_read;
        if (!seen) check("read_launch", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wn, rc, cnt;
        bit seen;

        vecs[0]  = '{18'h5, 18'h0, 18'h0, 1'b0, 18'h0};
        vecs[1]  = '{18'h5, 18'h0, 18'h0, 1'b0, 18'h0};
        vecs[2]  = '{18'h5, 18'h0, 18'h0, 1'b0, 18'h0};
        vecs[3]  = '{18'h5, 18'h0, 18'h5, 1'b1, 18'h5};
        vecs[4]  = '{18'h5, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[5]  = '{18'h1, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[6]  = '{18'h0, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[7]  = '{18'h1, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[8]  = '{18'h1, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[9]  = '{18'h1, 18'h0, 18'h5, 1'b0, 18'h5};
        vecs[10] = '{18'h1, 18'h0, 18'h1, 1'b1, 18'h5};
        vecs[11] = '{18'h0, 18'h0, 18'h1, 1'b0, 18'h5};
        vecs[12] = '{18'h0, 18'h0, 18'h1, 1'b0, 18'h5};
        vecs[13] = '{18'h0, 18'h0, 18'h1, 1'b0, 18'h5};
        vecs[14] = '{18'h0, 18'h0, 18'h0, 1'b1, 18'h5};
        vecs[15] = '{18'h4, 18'h1, 18'h0, 1'b0, 18'h4};
        vecs[16] = '{18'h4, 18'h0, 18'h0, 1'b0, 18'h4};
        vecs[17] = '{18'h4, 18'h0, 18'h0, 1'b0, 18'h4};
        vecs[18] = '{18'h4, 18'h4, 18'h4, 1'b1, 18'h4};

        reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0;
        avm_readdata = '0; avm_readdatavalid = 1'b0;
        edge_clear = '0; irq_mask = ALL;
        repeat (3) @(negedge clk);
        check("rst_read",    {31'd0, avm_read},   32'd0);
        check("rst_addr",    {30'd0, avm_address}, 32'd0);
        check("rst_stable",  {14'd0, sw_stable},   32'd0);
        check("rst_changed", {31'd0, sw_changed},  32'd0);
        check("rst_edge",    {14'd0, edge_capture}, 32'd0);
        check("rst_irq",     {31'd0, irq},         32'd0);
        check("rst_buserr",  {31'd0, bus_error},   32'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // Debounce, bounce rejection, edge capture and same-cycle set/clear.
        for (int i = 0; i < 19; i++) begin
            poll(vecs[i].data, 0, 1'b1, vecs[i].clr, wn, rc);
            if (i > 0) check($sformatf("v%0d_gap", i), wn, P);
            check($sformatf("v%0d_stable", i),  {14'd0, sw_stable},    {14'd0, vecs[i].exp_stable});
            check($sformatf("v%0d_changed", i), {31'd0, sw_changed},   {31'd0, vecs[i].exp_changed});
            check($sformatf("v%0d_edge", i),    {14'd0, edge_capture}, {14'd0, vecs[i].exp_edge});
            check($sformatf("v%0d_irq", i),     {31'd0, irq},          {31'd0, vecs[i].exp_edge != '0});
            check($sformatf("v%0d_buserr", i),  {31'd0, bus_error},    32'd0);
        end
        @(negedge clk);
        check("changed_pulse_ends", {31'd0, sw_changed}, 32'd0);

        // Mask gates irq combinationally; an idle clear drops the flag.
        irq_mask = '0;
        #1 check("irq_masked", {31'd0, irq}, 32'd0);
        irq_mask = ALL;
        #1 check("irq_unmasked", {31'd0, irq}, 32'd1);
        @(negedge clk);
        edge_clear = 18'h4;
        @(negedge clk);
        edge_clear = '0;
        check("clr_edge", {14'd0, edge_capture}, 32'd0);
        check("clr_irq",  {31'd0, irq},          32'd0);

        // Stalled read: request held for all stall cycles plus the accept.
        poll(18'h4, 5, 1'b1, '0, wn, rc);
        check("stall_rd_cycles", rc, 6);
        check("stall_buserr",    {31'd0, bus_error}, 32'd0);
        check("stall_stable",    {14'd0, sw_stable}, 32'h4);
        check("stall_changed",   {31'd0, sw_changed}, 32'd0);

        // enable drops in WAIT: transaction completes, then no new reads.
        avm_waitrequest = 1'b0;
        wait_read(seen);
        @(negedge clk);
        enable            = 1'b0;
        avm_readdata      = {14'd0, 18'h4};
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (avm_read) cnt++;
        end
        check("disabled_no_read", cnt, 0);
        check("disabled_buserr",  {31'd0, bus_error}, 32'd0);

        // Read timeout: bus_error exactly TIMEOUT_CYCLES after entering WAIT.
        enable = 1'b1;
        poll(18'h0, 0, 1'b0, '0, wn, rc);
        repeat (T - 1) @(negedge clk);
        check("timeout_before", {31'd0, bus_error}, 32'd0);
        @(negedge clk);
        check("timeout_at",     {31'd0, bus_error}, 32'd1);
        check("timeout_read",   {31'd0, avm_read},  32'd0);
        avm_readdata      = {14'd0, ALL};
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        check("late_stable",  {14'd0, sw_stable},  32'h4);
        check("late_changed", {31'd0, sw_changed}, 32'd0);
        poll(18'h4, 0, 1'b1, '0, wn, rc);
        check("timeout_gap",     wn, P - 2);
        check("post_to_stable",  {14'd0, sw_stable}, 32'h4);
        check("post_to_buserr",  {31'd0, bus_error}, 32'd1);

        // Build up non-zero state before the mid-READ reset.
        for (int k = 0; k < D; k++) poll(18'h0, 0, 1'b1, '0, wn, rc);
        for (int k = 0; k < D; k++) poll(18'h4, 0, 1'b1, '0, wn, rc);
        check("pre_rst_stable", {14'd0, sw_stable},    32'h4);
        check("pre_rst_edge",   {14'd0, edge_capture}, 32'h4);

        avm_waitrequest = 1'b1;
        wait_read(seen);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_read",    {31'd0, avm_read},     32'd0);
        check("mid_rst_stable",  {14'd0, sw_stable},    32'd0);
        check("mid_rst_changed", {31'd0, sw_changed},   32'd0);
        check("mid_rst_edge",    {14'd0, edge_capture}, 32'd0);
        check("mid_rst_irq",     {31'd0, irq},          32'd0);
        check("mid_rst_buserr",  {31'd0, bus_error},    32'd0);
        reset             = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = {14'd0, ALL};
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        check("post_rst_read",   {31'd0, avm_read},  32'd0);
        check("post_rst_stable", {14'd0, sw_stable}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
